apb_regbank_slave: RTL and testbench
====================================

# apb_regbank_slave

APB completer that sits directly downstream of the AXI4-Lite-to-APB bridge, occupying one PSEL line and one address window. It holds NUM_REGS 32-bit registers with byte-strobed writes, mirrors hardware status into read-only slots and inserts programmable wait states. It signals PSLVERR on decode, alignment and read-only violations, so every bridge response path can be exercised end to end.

## Interface
- BASE_ADDR, 32'h00000000, byte base of the window; the bridge region start for this PSEL bit.
- NUM_REGS, 16, number of 32-bit registers; 1..16.
- RO_MASK, 16'h0000, bit i=1 makes register i read-only; reads return status_in word i.
- WAIT_CYCLES, 2, PREADY-low cycles in the access phase; 0..15.
- s_axi_clk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-low; clock s_axi_clk.
- paddr  in  32  byte address.
- pprot  in  3  protection; accepted, ignored.
- psel  in  1  select, one bit of the bridge's m_apb_psel.
- penable  in  1  access phase.
- pwrite  in  1  1=write.
- pwdata  in  32  write data.
- pstrb  in  4  byte lanes.
- pready  out  1  transfer complete.
- prdata  out  32  read data, valid with pready.
- pslverr  out  1  error, valid with pready.
- status_in  in  NUM_REGS*32  hardware status; word i at [32i+31:32i].
- reg_out  out  NUM_REGS*32  current register contents for hardware.

## Operation
- Offset = paddr − BASE_ADDR; index = offset[31:2].
- Error on any one of: offset[1:0]≠0; index ≥ NUM_REGS (also covers paddr < BASE_ADDR via unsigned wrap); write to an RO_MASK register.
- Errored writes leave all registers unchanged. Errored reads return prdata=0.
- Good write: byte k of register[index] ← pwdata byte k for each pstrb[k]=1. pstrb=0 is a legal no-op with OKAY.
- Good read of an RW register returns the stored value. Good read of an RO register returns status_in, sampled in the completing cycle.
- RO registers: reg_out word is 0, and they hold no storage.
- FSM states:
  - IDLE: on psel&!penable (setup), latch index, error flag and pwrite, load the wait counter with WAIT_CYCLES, go to ACCESS.
  - ACCESS: with psel&penable, decrement the counter while nonzero. At zero, pready=1 and the write/read completes, then go to IDLE.
  - ACCESS, psel low: abort. No write, no pready, go to IDLE.
- Back-to-back: a setup arriving in the cycle after completion is accepted normally; no idle cycle is required beyond APB's own.
- Address, data and strobe are held stable by the requester through access. The write uses the latched index and the live pwdata/pstrb at completion.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, all registers 0, FSM=IDLE, counter=0.
- Reset is asynchronous mid-transfer. It returns to IDLE, and a partial write is never committed.
- pready, prdata and pslverr are registered-decode outputs, driven combinationally from FSM state and counter. All three are 0 whenever not completing.
- Latency: setup in cycle T, pready high in cycle T+1+WAIT_CYCLES.
- Register update is visible on reg_out in the cycle after the pready cycle.
- Simultaneous hardware status change and read: the value present in the completing cycle is returned.

## Configuration
- APB_REGBANK_WAIT_EN:
  - Defined: the wait counter and WAIT_CYCLES behave as above.
  - Undefined: the counter is not built and WAIT_CYCLES is ignored. pready=1 in the first access cycle (zero-wait); all other behaviour is unchanged.

## Structure
- Shared package apb_pkg holds:
  - FSM state typedef (IDLE, ACCESS).
  - APB response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; these also serve bridge bresp/rresp mapping.
  - Byte-lane merge function.
- One sub-module, apb_addr_decode: combinational offset/index/error computation, reused by other completers.

## Test plan
- Write 32'hDEADBEEF, pstrb 4'hF to BASE+0x8, then read BASE+0x8 -> prdata 32'hDEADBEEF, pslverr 0, pready exactly WAIT_CYCLES+1 cycles after setup.
- Reg 3 = 32'h11223344, then write 32'hAABBCCDD with pstrb 4'b0101 -> read 32'h11BB33DD.
- RO_MASK=16'h0002, status_in word1 = 32'hCAFE0001: write BASE+0x4 -> pslverr 1, reg unchanged; read -> 32'hCAFE0001, pslverr 0.
- Read BASE+0x40 (NUM_REGS=16) and BASE+0x2 -> pslverr 1, prdata 0. Write BASE+0x41 -> pslverr 1, no register changes.
- Assert s_axi_aresetn low during a write's wait cycle -> pready 0, target register stays 0 after reset release.
- psel dropped during the access wait -> no pready, no write. The next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, response codes and byte-lane merge.
package apb_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } apb_state_e;

    // Response encodings shared with the bridge's bresp/rresp mapping.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational window decode for an APB completer: register index plus a single error flag
// covering misalignment, out-of-window (including below-base wrap) and writes to read-only slots.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [15:0] RO_MASK   = 16'h0000,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [31:0]      i_paddr,
    input  logic             i_pwrite,
    output logic [IDX_W-1:0] o_index,
    output logic             o_err
);

    logic [31:0] w_offset;
    logic [29:0] w_word;
    logic        w_align_err;
    logic        w_range_err;
    logic        w_ro_err;

    // Unsigned wrap turns addresses below the base into huge offsets, caught by the range test.
    assign w_offset    = i_paddr - BASE_ADDR;
    assign w_word      = w_offset[31:2];
    assign w_align_err = (w_offset[1:0] != 2'b00);
    assign w_range_err = (w_word >= 30'(NUM_REGS));
    assign o_index     = w_word[IDX_W-1:0];
    assign w_ro_err    = i_pwrite && !w_range_err && RO_MASK[o_index];
    assign o_err       = w_align_err || w_range_err || w_ro_err;

endmodule

// File: rtl/apb_regbank_slave.sv
// APB register bank completer with read-only status slots and programmable wait states.
// Optional build macro APB_REGBANK_WAIT_EN enables the wait counter; otherwise zero-wait.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned NUM_REGS    = 16,
    parameter logic [15:0] RO_MASK     = 16'h0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                     s_axi_clk,
    input  logic                     s_axi_aresetn,
    input  logic [31:0]              paddr,
    input  logic [2:0]               pprot,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              pwdata,
    input  logic [3:0]               pstrb,
    output logic                     pready,
    output logic [31:0]              prdata,
    output logic                     pslverr,
    input  logic [NUM_REGS*32-1:0]   status_in,
    output logic [NUM_REGS*32-1:0]   reg_out
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e       r_state;
    apb_state_e       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             r_err;
    logic             w_err_next;
    logic             r_write;
    logic             w_write_next;
    logic [IDX_W-1:0] w_dec_idx;
    logic             w_dec_err;
    logic             w_cnt_zero;
    logic             w_complete;
    logic             w_do_write;
    logic [1:0]       w_resp;
    logic [31:0]      w_rdata;
    logic [31:0]      w_regs   [NUM_REGS];
    logic [31:0]      w_status [NUM_REGS];
    logic             unused_pprot;

    assign unused_pprot = ^pprot;

    apb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .RO_MASK   (RO_MASK),
        .IDX_W     (IDX_W)
    ) u_decode (
        .i_paddr  (paddr),
        .i_pwrite (pwrite),
        .o_index  (w_dec_idx),
        .o_err    (w_dec_err)
    );

`ifdef APB_REGBANK_WAIT_EN
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    assign w_cnt_zero = (r_cnt == 4'd0);

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;

    assign w_cnt_zero = 1'b1;
`endif

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_err   <= w_err_next;
            r_write <= w_write_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = r_err;
        w_write_next = r_write;
        w_complete   = 1'b0;
`ifdef APB_REGBANK_WAIT_EN
        w_cnt_next   = r_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                if (psel && !penable) begin
                    w_state_next = StAccess;
                    w_idx_next   = w_dec_idx;
                    w_err_next   = w_dec_err;
                    w_write_next = pwrite;
`ifdef APB_REGBANK_WAIT_EN
                    w_cnt_next   = 4'(WAIT_CYCLES);
`endif
                end
            end
            StAccess: begin
                // Requester withdrew select: drop the transfer without committing anything.
                if (!psel) begin
                    w_state_next = StIdle;
                end else if (penable) begin
                    if (w_cnt_zero) begin
                        w_complete   = 1'b1;
                        w_state_next = StIdle;
                    end
`ifdef APB_REGBANK_WAIT_EN
                    else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
`endif
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_resp     = r_err ? RESP_SLVERR : RESP_OKAY;
    assign w_do_write = w_complete && !r_err && r_write;
    assign w_rdata    = RO_MASK[r_idx] ? w_status[r_idx] : w_regs[r_idx];

    assign pready  = w_complete;
    assign pslverr = w_complete && (w_resp == RESP_SLVERR);
    assign prdata  = (w_complete && !r_err && !r_write) ? w_rdata : 32'h0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign w_status[i] = status_in[32*i +: 32];

        if (RO_MASK[i]) begin : g_ro
            assign w_regs[i] = 32'h0;
        end else begin : g_rw
            logic [31:0] r_word;

            always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    r_word <= 32'h0;
                end else if (w_do_write && (r_idx == IDX_W'(i))) begin
                    r_word <= byte_merge(r_word, pwdata, pstrb);
                end
            end

            assign w_regs[i] = r_word;
        end

        assign reg_out[32*i +: 32] = w_regs[i];
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench for apb_regbank_slave: directed cases plus randomized transfers against
// an array-based reference model of the register window.
module tb_apb_regbank_slave;

    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam int unsigned NREGS    = 16;
    localparam logic [15:0] RO       = 16'h0102;
    localparam int unsigned WAIT     = 2;
`ifdef APB_REGBANK_WAIT_EN
    localparam int EXP_LAT = WAIT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic                    s_axi_clk = 1'b0;
    logic                    s_axi_aresetn;
    logic [31:0]             paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [31:0]             pwdata;
    logic [3:0]              pstrb;
    logic                    pready;
    logic [31:0]             prdata;
    logic                    pslverr;
    logic [NREGS*32-1:0]     status_in;
    logic [NREGS*32-1:0]     reg_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model [NREGS];

    always #5 s_axi_clk = ~s_axi_clk;

    apb_regbank_slave #(
        .BASE_ADDR   (BASE),
        .NUM_REGS    (NREGS),
        .RO_MASK     (RO),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .s_axi_clk     (s_axi_clk),
        .s_axi_aresetn (s_axi_aresetn),
        .paddr         (paddr),
        .pprot         (pprot),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .pwdata        (pwdata),
        .pstrb         (pstrb),
        .pready        (pready),
        .prdata        (prdata),
        .pslverr       (pslverr),
        .status_in     (status_in),
        .reg_out       (reg_out)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] addr, input logic wr);
        logic [31:0] off;
        off = addr - BASE;
        if (off[1:0] != 2'b00) return 1'b1;
        if ((off >> 2) >= NREGS) return 1'b1;
        if (wr && RO[off[5:2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [511:0] exp_regout();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[32*i +: 32] = RO[i] ? 32'h0 : model[i];
        end
        return v;
    endfunction

    task automatic churn_status();
        int unsigned w;
        w = $urandom_range(0, NREGS - 1);
        status_in[32*w +: 32] = $urandom;
    endtask

    // Drives one transfer starting at a falling edge; returns at the falling edge after completion.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic churn,
                            output logic [31:0] rdata, output logic err, output int lat);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = 3'($urandom);
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge s_axi_clk);
        penable = 1'b1;
        lat = 1;
        if (churn) churn_status();
        #1;
        while (!pready && lat < 40) begin
            @(negedge s_axi_clk);
            if (churn) churn_status();
            #1;
            lat++;
        end
        rdata = prdata;
        err   = pslverr;
        @(negedge s_axi_clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic churn,
                           output logic [31:0] rdata, output logic err);
        int          lat;
        logic        eerr;
        logic [31:0] off;
        logic [31:0] erd;
        apb_xfer(addr, wr, wdata, strb, churn, rdata, err, lat);
        eerr = exp_err(addr, wr);
        off  = addr - BASE;
        check_eq({tag, "_lat"}, 512'(lat), 512'(EXP_LAT));
        check_eq({tag, "_err"}, 512'(err), 512'(eerr));
        if (!wr) begin
            if (eerr) erd = 32'h0;
            else if (RO[off[5:2]]) erd = status_in[32*off[5:2] +: 32];
            else erd = model[off[5:2]];
            check_eq({tag, "_rdata"}, 512'(rdata), 512'(erd));
        end else if (!eerr) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) model[off[5:2]][8*k +: 8] = wdata[8*k +: 8];
            end
        end
        check_eq({tag, "_regout"}, reg_out, exp_regout());
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        s_axi_aresetn = 1'b0;
        paddr = '0; pprot = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; status_in = '0;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;

        repeat (2) @(negedge s_axi_clk);
        check_eq("rst_pready", 512'(pready), 512'(0));
        check_eq("rst_prdata", 512'(prdata), 512'(0));
        check_eq("rst_pslverr", 512'(pslverr), 512'(0));
        check_eq("rst_regout", reg_out, '0);
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_clk);

        do_xfer("w8", BASE + 32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, rd, er);
        do_xfer("r8", BASE + 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("r8_const", 512'(rd), 512'(32'hDEADBEEF));

        do_xfer("w3a", BASE + 32'hC, 1'b1, 32'h11223344, 4'hF, 1'b0, rd, er);
        do_xfer("w3b", BASE + 32'hC, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er);
        do_xfer("r3", BASE + 32'hC, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("r3_const", 512'(rd), 512'(32'h11BB33DD));
        do_xfer("w3z", BASE + 32'hC, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er);

        status_in[63:32] = 32'hCAFE0001;
        do_xfer("wro", BASE + 32'h4, 1'b1, 32'h12345678, 4'hF, 1'b0, rd, er);
        check_eq("wro_const", 512'(er), 512'(1));
        do_xfer("rro", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("rro_const", 512'(rd), 512'(32'hCAFE0001));

        do_xfer("r40", BASE + 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        do_xfer("r02", BASE + 32'h2, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        do_xfer("w41", BASE + 32'h41, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er);
        do_xfer("rlow", BASE - 32'h4, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);

        // Abort: select dropped while the completer is in its access phase.
        paddr = BASE + 32'h14; pwrite = 1'b1; pwdata = 32'h5555AAAA; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(negedge s_axi_clk);
        if (EXP_LAT > 1) begin
            penable = 1'b1;
            @(negedge s_axi_clk);
        end
        psel = 1'b0; penable = 1'b0;
        #1;
        check_eq("abort_pready", 512'(pready), 512'(0));
        @(negedge s_axi_clk);
        check_eq("abort_regout", reg_out, exp_regout());
        do_xfer("post_abort", BASE + 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
        do_xfer("post_abort_w", BASE + 32'h18, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, rd, er);

        // Asynchronous reset in the middle of a write's access phase.
        paddr = BASE + 32'h1C; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(negedge s_axi_clk);
        penable = 1'b1;
        #2;
        s_axi_aresetn = 1'b0;
        #1;
        check_eq("rst_mid_pready", 512'(pready), 512'(0));
        @(negedge s_axi_clk);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        @(negedge s_axi_clk);
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_clk);
        check_eq("rst_mid_regout", reg_out, '0);
        do_xfer("rst_mid_r7", BASE + 32'h1C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);

        for (int n = 0; n < 300; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            if (kind < 7) a = BASE + 4 * $urandom_range(0, NREGS - 1);
            else if (kind == 7) a = BASE + 4 * $urandom_range(0, NREGS - 1) + $urandom_range(1, 3);
            else if (kind == 8) a = BASE + 4 * (NREGS + $urandom_range(0, 7));
            else a = BASE - 4 * $urandom_range(1, 8);
            do_xfer("rnd", a, 1'($urandom), $urandom, 4'($urandom), 1'b1, rd, er);
            repeat ($urandom_range(0, 2)) @(negedge s_axi_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
